// File: rtl/regs_wb_ctrl.sv
// Register-file writeback initiator: arbitrates ALU results and buffered load
// returns onto one write port and tracks in-flight loads for decode hazard stalls.
module regs_wb_ctrl #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int LD_DEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  ld_issue,
    input  logic [REG_ADDR_W-1:0] ld_issue_rd,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [XLEN-1:0]       ld_data,
    input  logic [REG_ADDR_W-1:0] src1_addr,
    input  logic [REG_ADDR_W-1:0] src2_addr,
    input  logic [REG_ADDR_W-1:0] dst_addr,
    output logic                  stall,
    output logic                  write_en,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic [XLEN-1:0]       write_data
);

    localparam int PTR_W  = $clog2(LD_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int NUM_RG = 1 << REG_ADDR_W;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_FIFO
    } src_e;

    // Load-return FIFO
    logic [REG_ADDR_W-1:0] fifo_rd_q   [LD_DEPTH];
    logic [XLEN-1:0]       fifo_data_q [LD_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic [NUM_RG-1:0]     pending_q, pending_d;
    logic                  write_en_q, write_en_d;
    logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]       write_data_q, write_data_d;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    src_e                  src;
    logic [REG_ADDR_W-1:0] win_rd;
    logic [XLEN-1:0]       win_data;

    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        fifo_full  = (count_q == CNT_W'(LD_DEPTH));
        fifo_empty = (count_q == '0);
        ld_ready   = !rst && !fifo_full;
        alu_ready  = !rst && !fifo_full;
        push       = ld_valid && ld_ready;

        if (fifo_full)       src = SRC_FIFO;
        else if (alu_valid)  src = SRC_ALU;
        else if (!fifo_empty) src = SRC_FIFO;
        else                 src = SRC_NONE;

        pop      = (src == SRC_FIFO);
        win_rd   = pop ? fifo_rd_q[rd_ptr_q]   : alu_rd;
        win_data = pop ? fifo_data_q[rd_ptr_q] : alu_data;

        // x0 writes are consumed but never reach the register file.
        write_en_d   = 1'b0;
        rd_addr_d    = rd_addr_q;
        write_data_d = write_data_q;
        if (src != SRC_NONE && win_rd != '0) begin
            write_en_d   = 1'b1;
            rd_addr_d    = win_rd;
            write_data_d = win_data;
        end

        // Clear applied before set so a same-cycle reissue keeps the register pending.
        pending_d = pending_q;
        if (pop && win_rd != '0)
            pending_d[win_rd] = 1'b0;
        if (ld_issue && ld_issue_rd != '0)
            pending_d[ld_issue_rd] = 1'b1;

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        stall = !rst && (pending_q[src1_addr] || pending_q[src2_addr] || pending_q[dst_addr]);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pending_q    <= '0;
            write_en_q   <= 1'b0;
            rd_addr_q    <= '0;
            write_data_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            pending_q    <= pending_d;
            write_en_q   <= write_en_d;
            rd_addr_q    <= rd_addr_d;
            write_data_q <= write_data_d;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; the count and pointers
    // alone decide which entries are valid, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= ld_rd;
            fifo_data_q[wr_ptr_q] <= ld_data;
        end
    end

    assign write_en   = write_en_q;
    assign rd_addr    = rd_addr_q;
    assign write_data = write_data_q;

endmodule

// File: tb/tb_regs_wb_ctrl.sv
// Directed bench for regs_wb_ctrl: hand-computed expectations for writeback
// arbitration, load FIFO buffering, scoreboard stalls and reset behaviour.
module tb_regs_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [4:0]  src1_addr;
    logic [4:0]  src2_addr;
    logic [4:0]  dst_addr;
    logic        stall;
    logic        write_en;
    logic [4:0]  rd_addr;
    logic [31:0] write_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regs_wb_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .ld_issue   (ld_issue),
        .ld_issue_rd(ld_issue_rd),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .src1_addr  (src1_addr),
        .src2_addr  (src2_addr),
        .dst_addr   (dst_addr),
        .stall      (stall),
        .write_en   (write_en),
        .rd_addr    (rd_addr),
        .write_data (write_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle; registered outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check one write-port beat.
    task automatic check_wr(input string tag, input logic en, input logic [4:0] rd,
                            input logic [31:0] data);
        check({tag, ".we"}, 32'(write_en), 32'(en));
        check({tag, ".rd"}, 32'(rd_addr), 32'(rd));
        check({tag, ".wd"}, write_data, data);
    endtask

    initial begin
        rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_issue = 1'b0; ld_issue_rd = '0; ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
        src1_addr = '0; src2_addr = '0; dst_addr = '0;
        tick(); tick();
        check("rst.alu_ready", 32'(alu_ready), 0);
        check("rst.ld_ready", 32'(ld_ready), 0);
        check("rst.stall", 32'(stall), 0);
        check_wr("rst", 1'b0, 5'd0, 32'h0);
        rst = 1'b0;
        #1;
        check("idle.ld_ready", 32'(ld_ready), 1);

        // 1: single ALU write, one-cycle latency then deassert
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1 check("t1.alu_ready", 32'(alu_ready), 1);
        tick();
        alu_valid = 1'b0;
        check_wr("t1.n1", 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        check_wr("t1.n2", 1'b0, 5'd5, 32'hDEADBEEF);

        // 2: load hazard on rs1, released when the load writes back
        ld_issue = 1'b1; ld_issue_rd = 5'd7;
        tick();
        ld_issue = 1'b0; src1_addr = 5'd7;
        #1 check("t2.stall_set", 32'(stall), 1);
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h00001234;
        #1 check("t2.ld_ready", 32'(ld_ready), 1);
        tick();
        ld_valid = 1'b0;
        check("t2.m1.we", 32'(write_en), 0);
        check("t2.m1.stall", 32'(stall), 1);
        tick();
        check_wr("t2.m2", 1'b1, 5'd7, 32'h00001234);
        check("t2.m2.stall", 32'(stall), 0);
        src1_addr = 5'd0;

        // 4: x0 writes are accepted but never reach the register file
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
        ld_issue = 1'b1; ld_issue_rd = 5'd0;
        #1 check("t4.alu_ready", 32'(alu_ready), 1);
        tick();
        alu_valid = 1'b0; ld_issue = 1'b0;
        check_wr("t4.x0", 1'b0, 5'd7, 32'h00001234);
        check("t4.x0_stall", 32'(stall), 0);

        // 3: ALU held valid while two load returns fill the FIFO
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA0;
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h33;
        tick();
        check_wr("t3.c0", 1'b1, 5'd10, 32'hA0);
        alu_rd = 5'd11; alu_data = 32'hA1;
        ld_rd = 5'd4; ld_data = 32'h44;
        tick();
        check_wr("t3.c1", 1'b1, 5'd11, 32'hA1);
        ld_valid = 1'b0;
        alu_rd = 5'd12; alu_data = 32'hA2;
        #1;
        check("t3.full_ld_ready", 32'(ld_ready), 0);
        check("t3.full_alu_ready", 32'(alu_ready), 0);
        tick();
        check_wr("t3.c2", 1'b1, 5'd3, 32'h33);
        check("t3.c3.alu_ready", 32'(alu_ready), 1);
        tick();
        check_wr("t3.c3", 1'b1, 5'd12, 32'hA2);
        alu_valid = 1'b0;
        tick();
        check_wr("t3.c4", 1'b1, 5'd4, 32'h44);
        tick();
        check("t3.drain", 32'(write_en), 0);

        // 5: load writeback of x9 on the same edge as a new issue to x9
        ld_issue = 1'b1; ld_issue_rd = 5'd9;
        tick();
        ld_issue = 1'b0;
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
        tick();
        ld_valid = 1'b0;
        ld_issue = 1'b1; ld_issue_rd = 5'd9; src2_addr = 5'd9;
        tick();
        ld_issue = 1'b0;
        check_wr("t5.wb", 1'b1, 5'd9, 32'h99);
        check("t5.stall_kept", 32'(stall), 1);
        tick();
        check("t5.stall_persist", 32'(stall), 1);
        src2_addr = 5'd0; dst_addr = 5'd9;
        #1 check("t5.stall_dst", 32'(stall), 1);
        dst_addr = 5'd0;

        // 6: reset while the FIFO holds two entries and x16 is pending
        alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'hC0;
        ld_valid = 1'b1; ld_rd = 5'd14; ld_data = 32'hE0;
        ld_issue = 1'b1; ld_issue_rd = 5'd16;
        tick();
        ld_issue = 1'b0;
        ld_rd = 5'd15; ld_data = 32'hF0;
        tick();
        alu_valid = 1'b0; ld_valid = 1'b0;
        #1 check("t6.full", 32'(ld_ready), 0);
        rst = 1'b1; src1_addr = 5'd16;
        #1 check("t6.rst_stall", 32'(stall), 0);
        tick();
        check_wr("t6.rst", 1'b0, 5'd0, 32'h0);
        check("t6.rst_ld_ready", 32'(ld_ready), 0);
        rst = 1'b0;
        #1;
        check("t6.ld_ready", 32'(ld_ready), 1);
        check("t6.pending_clr", 32'(stall), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t6.no_we%0d", i), 32'(write_en), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
